// File: rtl/tlb_lookup_pkg.sv
// Shared field layout for the joint TLB: EntryHi/EntryLo bit positions,
// the uncached cache attribute and the packed entry record.
package tlb_lookup_pkg;

    localparam int VPN2_LSB = 13;
    localparam int VPN2_W   = 19;
    localparam int ASID_LSB = 0;
    localparam int ASID_W   = 8;
    localparam int PFN_LSB  = 6;
    localparam int PFN_W    = 20;
    localparam int C_LSB    = 3;
    localparam int C_W      = 3;
    localparam int D_BIT    = 2;
    localparam int V_BIT    = 1;
    localparam int G_BIT    = 0;

    localparam logic [C_W-1:0] C_UNCACHED = 3'b010;

    typedef struct packed {
        logic [PFN_W-1:0] pfn;
        logic [C_W-1:0]   c;
        logic             d;
        logic             v;
    } tlb_half_t;

    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
        logic              g;
        tlb_half_t         lo0;
        tlb_half_t         lo1;
    } tlb_entry_t;

    // EntryLo as software sees it; G is shared by both halves of a pair.
    function automatic logic [31:0] packLo(input tlb_half_t h, input logic g);
        return {6'b0, h.pfn, h.c, h.d, h.v, g};
    endfunction

endpackage

// File: rtl/tlb_entry_match.sv
// Compares one TLB entry against a VPN2/ASID pair; global entries ignore ASID.
module tlb_entry_match
    import tlb_lookup_pkg::*;
(
    input  logic [VPN2_W-1:0] entryVpn2_i,
    input  logic [ASID_W-1:0] entryAsid_i,
    input  logic              entryG_i,
    input  logic [VPN2_W-1:0] vpn2_i,
    input  logic [ASID_W-1:0] asid_i,
    output logic              hit_o
);

    assign hit_o = (entryVpn2_i == vpn2_i) && (entryG_i || (entryAsid_i == asid_i));

endmodule

// File: rtl/tlb_lookup.sv
// 16-entry MIPS32 joint TLB: registered translation port, CP0 TLBWI/TLBWR/
// TLBP/TLBR execution and the Random register.
module tlb_lookup
    import tlb_lookup_pkg::*;
#(
    parameter int NENTRIES = 16,
    parameter int IDXW     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_vaddr,
    input  logic            req_write,
    input  logic [7:0]      req_asid,
    output logic            resp_valid,
    output logic [31:0]     resp_paddr,
    output logic            resp_miss,
    output logic            resp_invalid,
    output logic            resp_modified,
    output logic            resp_uncached,
    input  logic            tlbwi,
    input  logic            tlbwr,
    input  logic            tlbp,
    input  logic            tlbr,
    input  logic [IDXW-1:0] cp0_index,
    input  logic [31:0]     cp0_entryhi,
    input  logic [31:0]     cp0_entrylo0,
    input  logic [31:0]     cp0_entrylo1,
    input  logic [IDXW-1:0] cp0_wired,
    input  logic            cp0_wired_we,
    output logic            op_done,
    output logic            probe_miss,
    output logic [IDXW-1:0] probe_index,
    output logic [31:0]     rd_entryhi,
    output logic [31:0]     rd_entrylo0,
    output logic [31:0]     rd_entrylo1,
    output logic [IDXW-1:0] random_o
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NENTRIES - 1);

    tlb_entry_t          entries_q [NENTRIES];
    logic [NENTRIES-1:0] lookupHit;
    logic [NENTRIES-1:0] probeHit;
    logic                lookupFound;
    logic [IDXW-1:0]     lookupIdx;
    logic                probeFound;
    logic [IDXW-1:0]     probeIdx;
    tlb_half_t           hitHalf;
    tlb_entry_t          newEntry;
    tlb_entry_t          readEntry;
    logic [IDXW-1:0]     writeIdx;
    logic                doWrite;
    logic                doProbe;
    logic                doRead;
    logic                reqAccept;
    logic [IDXW-1:0]     random_q;
    logic [IDXW-1:0]     random_d;

    logic                respValid_q;
    logic [31:0]         respPaddr_q;
    logic                respMiss_q;
    logic                respInvalid_q;
    logic                respModified_q;
    logic                respUncached_q;
    logic                opDone_q;
    logic                probeMiss_q;
    logic [IDXW-1:0]     probeIndex_q;
    logic [31:0]         rdEntryHi_q;
    logic [31:0]         rdEntryLo0_q;
    logic [31:0]         rdEntryLo1_q;

    logic                unusedBits;
    assign unusedBits = ^{cp0_entryhi[VPN2_LSB-1:ASID_W],
                          cp0_entrylo0[31:PFN_LSB+PFN_W],
                          cp0_entrylo1[31:PFN_LSB+PFN_W]};

    for (genvar i = 0; i < NENTRIES; i++) begin : gMatch
        tlb_entry_match uLookupMatch (
            .entryVpn2_i (entries_q[i].vpn2),
            .entryAsid_i (entries_q[i].asid),
            .entryG_i    (entries_q[i].g),
            .vpn2_i      (req_vaddr[VPN2_LSB +: VPN2_W]),
            .asid_i      (req_asid),
            .hit_o       (lookupHit[i])
        );
        tlb_entry_match uProbeMatch (
            .entryVpn2_i (entries_q[i].vpn2),
            .entryAsid_i (entries_q[i].asid),
            .entryG_i    (entries_q[i].g),
            .vpn2_i      (cp0_entryhi[VPN2_LSB +: VPN2_W]),
            .asid_i      (cp0_entryhi[ASID_LSB +: ASID_W]),
            .hit_o       (probeHit[i])
        );
    end

    // Scanning downwards leaves the lowest matching index as the winner.
    always_comb begin
        lookupFound = 1'b0;
        lookupIdx   = '0;
        probeFound  = 1'b0;
        probeIdx    = '0;
        for (int i = NENTRIES - 1; i >= 0; i--) begin
            if (lookupHit[i]) begin
                lookupFound = 1'b1;
                lookupIdx   = IDXW'(i);
            end
            if (probeHit[i]) begin
                probeFound = 1'b1;
                probeIdx   = IDXW'(i);
            end
        end
    end

    assign hitHalf   = req_vaddr[VPN2_LSB-1] ? entries_q[lookupIdx].lo1 : entries_q[lookupIdx].lo0;
    assign readEntry = entries_q[cp0_index];

    assign req_ready = ~(tlbwi | tlbwr | tlbp | tlbr);
    assign reqAccept = req_valid & req_ready;
    assign doWrite   = tlbwi | tlbwr;
    assign doProbe   = tlbp & ~doWrite;
    assign doRead    = tlbr & ~doWrite & ~tlbp;
    assign writeIdx  = tlbwi ? cp0_index : random_q;

    always_comb begin
        newEntry.vpn2  = cp0_entryhi[VPN2_LSB +: VPN2_W];
        newEntry.asid  = cp0_entryhi[ASID_LSB +: ASID_W];
        newEntry.g     = cp0_entrylo0[G_BIT] & cp0_entrylo1[G_BIT];
        newEntry.lo0.pfn = cp0_entrylo0[PFN_LSB +: PFN_W];
        newEntry.lo0.c   = cp0_entrylo0[C_LSB +: C_W];
        newEntry.lo0.d   = cp0_entrylo0[D_BIT];
        newEntry.lo0.v   = cp0_entrylo0[V_BIT];
        newEntry.lo1.pfn = cp0_entrylo1[PFN_LSB +: PFN_W];
        newEntry.lo1.c   = cp0_entrylo1[C_LSB +: C_W];
        newEntry.lo1.d   = cp0_entrylo1[D_BIT];
        newEntry.lo1.v   = cp0_entrylo1[V_BIT];
    end

    // A Wired value at the top of the range pins Random to the last entry.
    always_comb begin
        if (cp0_wired_we || (cp0_wired >= LAST_IDX) || (random_q == cp0_wired)) begin
            random_d = LAST_IDX;
        end else begin
            random_d = random_q - IDXW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NENTRIES; i++) begin
                entries_q[i] <= '0;
            end
        end else if (doWrite) begin
            entries_q[writeIdx] <= newEntry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            random_q       <= LAST_IDX;
            respValid_q    <= 1'b0;
            respPaddr_q    <= '0;
            respMiss_q     <= 1'b0;
            respInvalid_q  <= 1'b0;
            respModified_q <= 1'b0;
            respUncached_q <= 1'b0;
            opDone_q       <= 1'b0;
            probeMiss_q    <= 1'b0;
            probeIndex_q   <= '0;
            rdEntryHi_q    <= '0;
            rdEntryLo0_q   <= '0;
            rdEntryLo1_q   <= '0;
        end else begin
            random_q    <= random_d;
            respValid_q <= reqAccept;
            opDone_q    <= doProbe | doRead;
            if (reqAccept) begin
                respPaddr_q    <= lookupFound ? {hitHalf.pfn, req_vaddr[VPN2_LSB-2:0]} : '0;
                respMiss_q     <= ~lookupFound;
                respInvalid_q  <= lookupFound & ~hitHalf.v;
                respModified_q <= lookupFound & hitHalf.v & req_write & ~hitHalf.d;
                respUncached_q <= lookupFound & (hitHalf.c == C_UNCACHED);
            end
            if (doProbe) begin
                probeMiss_q  <= ~probeFound;
                probeIndex_q <= probeIdx;
            end
            if (doRead) begin
                rdEntryHi_q  <= {readEntry.vpn2, 5'b0, readEntry.asid};
                rdEntryLo0_q <= packLo(readEntry.lo0, readEntry.g);
                rdEntryLo1_q <= packLo(readEntry.lo1, readEntry.g);
            end
        end
    end

    assign resp_valid    = respValid_q;
    assign resp_paddr    = respPaddr_q;
    assign resp_miss     = respMiss_q;
    assign resp_invalid  = respInvalid_q;
    assign resp_modified = respModified_q;
    assign resp_uncached = respUncached_q;
    assign op_done       = opDone_q;
    assign probe_miss    = probeMiss_q;
    assign probe_index   = probeIndex_q;
    assign rd_entryhi    = rdEntryHi_q;
    assign rd_entrylo0   = rdEntryLo0_q;
    assign rd_entrylo1   = rdEntryLo1_q;
    assign random_o      = random_q;

endmodule

// File: tb/tb_tlb_lookup.sv
// Self-checking bench for tlb_lookup: directed scenarios followed by random
// traffic, all compared against an array-based TLB model.
module tb_tlb_lookup;

    localparam int NENT = 16;
    localparam int IW   = 4;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_vaddr;
    logic          req_write;
    logic [7:0]    req_asid;
    logic          resp_valid;
    logic [31:0]   resp_paddr;
    logic          resp_miss;
    logic          resp_invalid;
    logic          resp_modified;
    logic          resp_uncached;
    logic          tlbwi;
    logic          tlbwr;
    logic          tlbp;
    logic          tlbr;
    logic [IW-1:0] cp0_index;
    logic [31:0]   cp0_entryhi;
    logic [31:0]   cp0_entrylo0;
    logic [31:0]   cp0_entrylo1;
    logic [IW-1:0] cp0_wired;
    logic          cp0_wired_we;
    logic          op_done;
    logic          probe_miss;
    logic [IW-1:0] probe_index;
    logic [31:0]   rd_entryhi;
    logic [31:0]   rd_entrylo0;
    logic [31:0]   rd_entrylo1;
    logic [IW-1:0] random_o;

    tlb_lookup #(.NENTRIES(NENT), .IDXW(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .req_write(req_write), .req_asid(req_asid),
        .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_miss(resp_miss),
        .resp_invalid(resp_invalid), .resp_modified(resp_modified), .resp_uncached(resp_uncached),
        .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbp(tlbp), .tlbr(tlbr),
        .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi),
        .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
        .cp0_wired(cp0_wired), .cp0_wired_we(cp0_wired_we),
        .op_done(op_done), .probe_miss(probe_miss), .probe_index(probe_index),
        .rd_entryhi(rd_entryhi), .rd_entrylo0(rd_entrylo0), .rd_entrylo1(rd_entrylo1),
        .random_o(random_o)
    );

    typedef struct {
        bit        valid;
        bit [31:0] vaddr;
        bit        write;
        bit [7:0]  asid;
        bit        wi, wr, p, r;
        bit [3:0]  index;
        bit [31:0] hi, lo0, lo1;
        bit        wiredWe;
        bit [3:0]  wired;
    } stim_t;

    int checkCount = 0;
    int errorCount = 0;

    bit [18:0] mVpn2 [NENT];
    bit [7:0]  mAsid [NENT];
    bit        mG    [NENT];
    bit [19:0] mPfn  [NENT][2];
    bit [2:0]  mC    [NENT][2];
    bit        mD    [NENT][2];
    bit        mV    [NENT][2];
    int        mRandom;
    bit [3:0]  wiredVal = 0;

    bit        expRespValid, expMiss, expInvalid, expModified, expUncached;
    bit        expOpDone, expProbeMiss;
    int        expProbeIdx;
    bit [31:0] expPaddr, expRdHi, expRdLo0, expRdLo1;

    bit [18:0] vpnPool [4] = '{19'h00201, 19'h00200, 19'h12345, 19'h7ffff};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NENT; i++) begin
            mVpn2[i] = 0; mAsid[i] = 0; mG[i] = 0;
            for (int h = 0; h < 2; h++) begin
                mPfn[i][h] = 0; mC[i][h] = 0; mD[i][h] = 0; mV[i][h] = 0;
            end
        end
        mRandom = NENT - 1;
        expRespValid = 0; expMiss = 0; expInvalid = 0; expModified = 0; expUncached = 0;
        expOpDone = 0; expProbeMiss = 0; expProbeIdx = 0; expPaddr = 0;
        expRdHi = 0; expRdLo0 = 0; expRdLo1 = 0;
    endtask

    task automatic modelWrite(input int idx, input bit [31:0] hi, input bit [31:0] lo0, input bit [31:0] lo1);
        mVpn2[idx] = hi[31:13];
        mAsid[idx] = hi[7:0];
        mG[idx]    = lo0[0] & lo1[0];
        mPfn[idx][0] = lo0[25:6]; mC[idx][0] = lo0[5:3]; mD[idx][0] = lo0[2]; mV[idx][0] = lo0[1];
        mPfn[idx][1] = lo1[25:6]; mC[idx][1] = lo1[5:3]; mD[idx][1] = lo1[2]; mV[idx][1] = lo1[1];
    endtask

    function automatic int findEntry(input bit [18:0] vpn2, input bit [7:0] asid);
        for (int i = 0; i < NENT; i++) begin
            if (mVpn2[i] == vpn2 && (mG[i] || mAsid[i] == asid)) return i;
        end
        return -1;
    endfunction

    function automatic bit [31:0] loPacked(input int idx, input int h);
        return {6'b0, mPfn[idx][h], mC[idx][h], mD[idx][h], mV[idx][h], mG[idx]};
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s.valid = 0; s.vaddr = 0; s.write = 0; s.asid = 0;
        s.wi = 0; s.wr = 0; s.p = 0; s.r = 0; s.index = 0;
        s.hi = 0; s.lo0 = 0; s.lo1 = 0; s.wiredWe = 0; s.wired = wiredVal;
        return s;
    endfunction

    // Update the model from the inputs sampled at this edge, then compare.
    task automatic tick();
        int hit, half, idx;
        @(posedge clk);
        expRespValid = req_valid && !(tlbwi || tlbwr || tlbp || tlbr);
        expOpDone = 0;
        if (expRespValid) begin
            hit  = findEntry(req_vaddr[31:13], req_asid);
            half = int'(req_vaddr[12]);
            expMiss = (hit < 0);
            expPaddr = 0; expInvalid = 0; expModified = 0; expUncached = 0;
            if (hit >= 0) begin
                expPaddr    = {mPfn[hit][half], req_vaddr[11:0]};
                expInvalid  = !mV[hit][half];
                expModified = mV[hit][half] && req_write && !mD[hit][half];
                expUncached = (mC[hit][half] == 3'b010);
            end
        end
        if (tlbwi || tlbwr) begin
            idx = tlbwi ? int'(cp0_index) : mRandom;
            modelWrite(idx, cp0_entryhi, cp0_entrylo0, cp0_entrylo1);
        end else if (tlbp) begin
            expOpDone = 1;
            hit = findEntry(cp0_entryhi[31:13], cp0_entryhi[7:0]);
            expProbeMiss = (hit < 0);
            expProbeIdx  = (hit < 0) ? 0 : hit;
        end else if (tlbr) begin
            expOpDone = 1;
            idx = int'(cp0_index);
            expRdHi  = {mVpn2[idx], 5'b0, mAsid[idx]};
            expRdLo0 = loPacked(idx, 0);
            expRdLo1 = loPacked(idx, 1);
        end
        if (cp0_wired_we || int'(cp0_wired) >= NENT - 1 || mRandom == int'(cp0_wired))
            mRandom = NENT - 1;
        else
            mRandom = mRandom - 1;
        #1;
        checkOutput("resp_valid", 32'(resp_valid), 32'(expRespValid));
        if (expRespValid) begin
            checkOutput("resp_paddr", resp_paddr, expPaddr);
            checkOutput("resp_miss", 32'(resp_miss), 32'(expMiss));
            checkOutput("resp_invalid", 32'(resp_invalid), 32'(expInvalid));
            checkOutput("resp_modified", 32'(resp_modified), 32'(expModified));
            if (!expMiss && !expInvalid && !expModified)
                checkOutput("resp_uncached", 32'(resp_uncached), 32'(expUncached));
        end
        checkOutput("op_done", 32'(op_done), 32'(expOpDone));
        checkOutput("probe_miss", 32'(probe_miss), 32'(expProbeMiss));
        checkOutput("probe_index", 32'(probe_index), 32'(expProbeIdx));
        checkOutput("rd_entryhi", rd_entryhi, expRdHi);
        checkOutput("rd_entrylo0", rd_entrylo0, expRdLo0);
        checkOutput("rd_entrylo1", rd_entrylo1, expRdLo1);
        checkOutput("random_o", 32'(random_o), 32'(mRandom));
    endtask

    task automatic applyStimulus(input stim_t s);
        if (s.wiredWe) wiredVal = s.wired;
        req_valid = s.valid; req_vaddr = s.vaddr; req_write = s.write; req_asid = s.asid;
        tlbwi = s.wi; tlbwr = s.wr; tlbp = s.p; tlbr = s.r; cp0_index = s.index;
        cp0_entryhi = s.hi; cp0_entrylo0 = s.lo0; cp0_entrylo1 = s.lo1;
        cp0_wired_we = s.wiredWe; cp0_wired = wiredVal;
        #1;
        checkOutput("req_ready", 32'(req_ready), 32'(!(s.wi || s.wr || s.p || s.r)));
        tick();
    endtask

    task automatic doRequest(input bit [31:0] vaddr, input bit write, input bit [7:0] asid);
        stim_t s = idleStim();
        s.valid = 1; s.vaddr = vaddr; s.write = write; s.asid = asid;
        applyStimulus(s);
    endtask

    task automatic doWriteIndexed(input bit [3:0] index, input bit [31:0] hi, input bit [31:0] lo0, input bit [31:0] lo1);
        stim_t s = idleStim();
        s.wi = 1; s.index = index; s.hi = hi; s.lo0 = lo0; s.lo1 = lo1;
        applyStimulus(s);
    endtask

    task automatic doProbe(input bit [31:0] hi);
        stim_t s = idleStim();
        s.p = 1; s.hi = hi;
        applyStimulus(s);
    endtask

    task automatic doRead(input bit [3:0] index);
        stim_t s = idleStim();
        s.r = 1; s.index = index;
        applyStimulus(s);
    endtask

    initial begin
        stim_t s;
        int sel, k;

        rst = 1'b1;
        req_valid = 0; req_vaddr = 0; req_write = 0; req_asid = 0;
        tlbwi = 0; tlbwr = 0; tlbp = 0; tlbr = 0; cp0_index = 0;
        cp0_entryhi = 0; cp0_entrylo0 = 0; cp0_entrylo1 = 0;
        cp0_wired = 0; cp0_wired_we = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset_random", 32'(random_o), 32'd15);
        checkOutput("reset_op_done", 32'(op_done), 32'd0);
        checkOutput("reset_rd_entryhi", rd_entryhi, 32'd0);
        checkOutput("reset_resp_paddr", resp_paddr, 32'd0);
        rst = 1'b0;

        // Uncached even page, miss on neighbouring VPN2, then the odd half with/without global.
        doWriteIndexed(4'd3, 32'h00402005, 32'h00001016, 32'h00001817);
        doRequest(32'h00402123, 1'b0, 8'd5);
        checkOutput("uncached_paddr", resp_paddr, 32'h00040123);
        doRequest(32'h00400123, 1'b0, 8'd5);
        doRequest(32'h00403abc, 1'b0, 8'd9);
        checkOutput("nonglobal_miss", 32'(resp_miss), 32'd1);
        doWriteIndexed(4'd3, 32'h00402005, 32'h00001017, 32'h00001817);
        doRequest(32'h00403abc, 1'b0, 8'd9);
        checkOutput("global_odd_paddr", resp_paddr, 32'h00060abc);

        // Store to a clean page and to an invalid page.
        doWriteIndexed(4'd4, 32'h00800007, 32'h00001012, 32'h00001810);
        doRequest(32'h00800010, 1'b1, 8'd7);
        doRequest(32'h00801010, 1'b1, 8'd7);
        checkOutput("store_invalid", 32'(resp_invalid), 32'd1);

        // Wired = 4, then TLBWR landing on entry 7.
        s = idleStim(); s.wiredWe = 1; s.wired = 4'd4;
        applyStimulus(s);
        for (int n = 0; n < 20 && mRandom != 7; n++) applyStimulus(idleStim());
        checkOutput("random_reach7", 32'(random_o), 32'd7);
        s = idleStim(); s.wr = 1; s.hi = 32'h0abce1ff; s.lo0 = 32'h0000a5c7; s.lo1 = 32'h0000b5c3;
        applyStimulus(s);
        doRead(4'd7);
        checkOutput("tlbwr_entry7", rd_entryhi, 32'h0abce0ff);
        for (int n = 0; n < 16; n++) applyStimulus(idleStim());

        // Probe miss, then a duplicate VPN2 resolves to the lower index.
        doProbe(32'h7fffe003);
        checkOutput("probe_absent", 32'(probe_miss), 32'd1);
        doWriteIndexed(4'd9, 32'h12344005, 32'h00002006, 32'h00003006);
        doWriteIndexed(4'd2, 32'h12344005, 32'h00004006, 32'h00005006);
        doProbe(32'h12344005);
        checkOutput("probe_lowest", 32'(probe_index), 32'd2);

        // Request stalled by a concurrent TLBWI sees the new entry one cycle later.
        s = idleStim(); s.valid = 1; s.vaddr = 32'h00c00044; s.asid = 8'd1;
        s.wi = 1; s.index = 4'd5; s.hi = 32'h00c00001; s.lo0 = 32'h00003456; s.lo1 = 32'h00003457;
        applyStimulus(s);
        doRequest(32'h00c00044, 1'b0, 8'd1);

        // Reset while a response is on the outputs.
        doRequest(32'h00c00044, 1'b0, 8'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_mid_random", 32'(random_o), 32'd15);
        modelReset();
        wiredVal = 0;
        #1 rst = 1'b0;
        applyStimulus(idleStim());

        for (int n = 0; n < 600; n++) begin
            s = idleStim();
            sel = $urandom_range(0, 99);
            k = $urandom_range(0, 3);
            if (sel < 50) begin
                s.valid = 1; s.vaddr = {vpnPool[k], 13'($urandom)};
                s.write = 1'($urandom); s.asid = 8'($urandom_range(0, 3));
            end else if (sel < 62 || (sel >= 62 && sel < 68)) begin
                s.wi = (sel < 62); s.wr = (sel >= 62);
                s.index = 4'($urandom);
                s.hi = {vpnPool[k], 5'($urandom), 8'($urandom_range(0, 3))};
                s.lo0 = $urandom; s.lo1 = $urandom;
            end else if (sel < 76) begin
                s.p = 1; s.hi = {vpnPool[k], 5'($urandom), 8'($urandom_range(0, 3))};
            end else if (sel < 84) begin
                s.r = 1; s.index = 4'($urandom);
            end else if (sel < 88) begin
                s.wiredWe = 1; s.wired = 4'($urandom);
            end else if (sel < 94) begin
                s.valid = 1; s.vaddr = {vpnPool[k], 13'($urandom)}; s.asid = 8'($urandom_range(0, 3));
                s.wi = 1'($urandom); s.wr = 1'($urandom); s.p = 1'($urandom); s.r = 1;
                s.index = 4'($urandom);
                s.hi = {vpnPool[k], 5'($urandom), 8'($urandom_range(0, 3))};
                s.lo0 = $urandom; s.lo1 = $urandom;
            end
            applyStimulus(s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
